// File: rtl/pt2272_decoder.sv
// PT2272-style remote-control decoder.
// Measures slot-coded pulses on DIN, assembles 24 half-bits into 12 trits,
// compares the address against ADDR_CFG and requires two consecutive equal
// data words before it updates DATA_OUT, raises VT and pulses WORD_STB.
// VT falls VT_HOLD_SLOTS slots after the last confirmed word; DATA_OUT latches.
module pt2272_decoder #(
  parameter int SLOT_CLKS     = 16,
  parameter int VT_HOLD_SLOTS = 512
) (
  input  logic        INPUT_CLK,
  input  logic        RST_N,
  input  logic        DIN,
  input  logic [15:0] ADDR_CFG,
  output logic [3:0]  DATA_OUT,
  output logic        VT,
  output logic        WORD_STB
);

  localparam int CW = $clog2(8*SLOT_CLKS + 1);
  localparam int SW = $clog2(SLOT_CLKS);
  localparam int VW = $clog2(VT_HOLD_SLOTS + 1);

  // Pulse-width thresholds in clock cycles
  localparam logic [CW-1:0] SYNC_MIN  = CW'(8*SLOT_CLKS);
  localparam logic [CW-1:0] SYNC_LAST = CW'(8*SLOT_CLKS - 1);
  localparam logic [CW-1:0] GAP_MIN   = CW'(5*SLOT_CLKS);
  localparam logic [CW-1:0] HI_MAX    = CW'(5*SLOT_CLKS);
  localparam logic [CW-1:0] ONE_MIN   = CW'(2*SLOT_CLKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CLKS - 1);
  localparam logic [VW-1:0] VT_LOAD   = VW'(VT_HOLD_SLOTS);
  localparam logic [VW-1:0] VT_ONE    = VW'(1);
  localparam logic [4:0]    HALVES    = 5'd24;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HIGH  = 2'd1;
  localparam logic [1:0] LOW   = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic          din_meta, s_din;
  logic [1:0]    state, state_n;
  logic [CW-1:0] idle_cnt, idle_n;
  logic [CW-1:0] hi_cnt, hi_n;
  logic [CW-1:0] lo_cnt, lo_n;
  logic [4:0]    half_cnt, half_n;
  logic [23:0]   halves, halves_n;
  logic          abort;

  logic [SW-1:0] slot_cnt;
  logic          slot_tick;
  logic [VW-1:0] vt_cnt;
  logic          pend_vld;
  logic [3:0]    pend_data;

  logic [11:0][1:0] trit;
  logic             addr_ok, data_ok, match;
  logic [3:0]       rx_data;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge INPUT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      din_meta <= 1'b0;
      s_din    <= 1'b0;
    end else begin
      din_meta <= DIN;
      s_din    <= din_meta;
    end
  end

  // Halves shift in at the MSB, so after 24 halves the first one sits at bit 0.
  // Trit code is {first half, second half}, matching the ADDR_CFG encoding.
  for (genvar i = 0; i < 12; i++) begin : g_trit
    assign trit[i] = {halves[2*i], halves[2*i+1]};
  end

  // Word match: address trits equal the configuration, data trits are 0 or 1
  always_comb begin
    addr_ok = 1'b1;
    data_ok = 1'b1;
    rx_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (trit[i] != ADDR_CFG[2*i +: 2] || trit[i] == 2'b10) addr_ok = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      case (trit[8+j])
        2'b00:   rx_data[j] = 1'b0;
        2'b11:   rx_data[j] = 1'b1;
        default: data_ok    = 1'b0;
      endcase
    end
    match = addr_ok && data_ok;
  end

  // Line-state machine: measures high and low pulse widths, collects halves
  always_comb begin
    state_n  = state;
    idle_n   = idle_cnt;
    hi_n     = hi_cnt;
    lo_n     = lo_cnt;
    half_n   = half_cnt;
    halves_n = halves;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (s_din) begin
          idle_n = '0;
        end else if (idle_cnt >= SYNC_LAST) begin
          // A full sync gap: frame-ready, waiting for the first rise
          state_n = LOW;
          lo_n    = SYNC_MIN;
          half_n  = '0;
          idle_n  = '0;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (s_din) begin
          if (hi_cnt >= HI_MAX) begin
            state_n = IDLE;
            idle_n  = '0;
            abort   = 1'b1;
          end else begin
            hi_n = hi_cnt + 1'b1;
          end
        end else begin
          halves_n = {(hi_cnt >= ONE_MIN), halves[23:1]};
          half_n   = (half_cnt < HALVES) ? half_cnt + 1'b1 : half_cnt;
          lo_n     = CNT_ONE;
          state_n  = LOW;
        end
      end
      LOW: begin
        if (s_din) begin
          if (lo_cnt >= SYNC_MIN) begin
            // First rise after a sync gap starts a new word
            state_n = HIGH;
            hi_n    = CNT_ONE;
            half_n  = '0;
          end else if (lo_cnt < GAP_MIN && half_cnt < HALVES) begin
            state_n = HIGH;
            hi_n    = CNT_ONE;
          end else begin
            // Too-long mid-word low, or a 25th half-bit
            state_n = IDLE;
            idle_n  = '0;
            abort   = 1'b1;
          end
        end else begin
          if (lo_cnt < SYNC_MIN) lo_n = lo_cnt + 1'b1;
          if (lo_cnt == SYNC_LAST) begin
            if (half_cnt == HALVES) begin
              state_n = CHECK;
            end else begin
              // Partial word dropped; the gap itself is still a valid sync
              abort  = (half_cnt != 5'd0);
              half_n = '0;
            end
          end
        end
      end
      CHECK: begin
        state_n = LOW;
        lo_n    = SYNC_MIN;
        half_n  = '0;
      end
      default: begin
        state_n = IDLE;
        idle_n  = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge INPUT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idle_cnt <= '0;
      hi_cnt   <= '0;
      lo_cnt   <= '0;
      half_cnt <= '0;
      halves   <= '0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_n;
      hi_cnt   <= hi_n;
      lo_cnt   <= lo_n;
      half_cnt <= half_n;
      halves   <= halves_n;
    end
  end

  assign slot_tick = (slot_cnt == SLOT_LAST);

  // Pending word, confirmation, outputs and VT hold timer.
  // The CHECK branch is written last so a confirm overrides a same-cycle expiry.
  always_ff @(posedge INPUT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt  <= '0;
      vt_cnt    <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      DATA_OUT  <= '0;
      VT        <= 1'b0;
      WORD_STB  <= 1'b0;
    end else begin
      WORD_STB <= 1'b0;
      slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
      if (VT && slot_tick) begin
        if (vt_cnt <= VT_ONE) begin
          vt_cnt   <= '0;
          VT       <= 1'b0;
          pend_vld <= 1'b0;
        end else begin
          vt_cnt <= vt_cnt - 1'b1;
        end
      end
      if (abort) pend_vld <= 1'b0;
      if (state == CHECK) begin
        if (!match) begin
          pend_vld <= 1'b0;
        end else if (pend_vld && pend_data == rx_data) begin
          DATA_OUT <= rx_data;
          VT       <= 1'b1;
          WORD_STB <= 1'b1;
          vt_cnt   <= VT_LOAD;
          slot_cnt <= '0;
          pend_vld <= 1'b1;
        end else begin
          pend_vld  <= 1'b1;
          pend_data <= rx_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pt2272_decoder.sv
// Bench for pt2272_decoder: directed PT2262 words, scoreboard of expected
// strobes checked by an independent monitor, plus direct output checks.
module tb_pt2272_decoder;

  localparam int SLOT = 4;

  logic       INPUT_CLK = 1'b0;
  logic       RST_N;
  logic       DIN;
  logic [15:0] ADDR_CFG;
  logic [3:0] DATA_OUT;
  logic       VT;
  logic       WORD_STB;

  int n_chk  = 0;
  int n_pass = 0;
  int stb_cnt = 0;
  int cyc = 0;
  int last_stb_cyc = 0;
  logic [3:0] sb_q[$];

  pt2272_decoder #(.SLOT_CLKS(SLOT), .VT_HOLD_SLOTS(512)) dut (
    .INPUT_CLK(INPUT_CLK), .RST_N(RST_N), .DIN(DIN), .ADDR_CFG(ADDR_CFG),
    .DATA_OUT(DATA_OUT), .VT(VT), .WORD_STB(WORD_STB)
  );

  always #5 INPUT_CLK = ~INPUT_CLK;
  always @(posedge INPUT_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every strobe must match the oldest expected word
  always @(posedge INPUT_CLK) begin
    #1;
    if (WORD_STB === 1'b1) begin
      logic [3:0] e;
      stb_cnt++;
      last_stb_cyc = cyc;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_stb: strobe with DATA_OUT=%0h, none expected (cycle %0d)", DATA_OUT, cyc);
      end else begin
        e = sb_q.pop_front();
        check("stb_data", 32'(DATA_OUT), 32'(e));
        check("stb_vt", 32'(VT), 32'd1);
      end
    end
  end

  task automatic line(input logic v, input int slots);
    DIN = v;
    repeat (slots*SLOT) @(negedge INPUT_CLK);
  endtask

  task automatic send_half(input logic b);
    line(1'b1, b ? 3 : 1);
    line(1'b0, b ? 1 : 3);
  endtask

  // Trit code {first half, second half}: 00=0, 11=1, 01=F, 10=illegal
  task automatic send_trit(input logic [1:0] c);
    send_half(c[1]);
    send_half(c[0]);
  endtask

  task automatic send_word(input logic [15:0] acode, input logic [7:0] dcode);
    for (int i = 0; i < 8; i++) send_trit(acode[2*i +: 2]);
    for (int j = 0; j < 4; j++) send_trit(dcode[2*j +: 2]);
    line(1'b0, 31);
  endtask

  function automatic logic [7:0] dc(input logic [3:0] d);
    logic [7:0] r;
    for (int j = 0; j < 4; j++) r[2*j +: 2] = d[j] ? 2'b11 : 2'b00;
    return r;
  endfunction

  task automatic good(input logic [3:0] d);
    send_word(16'h5555, dc(d));
  endtask

  task automatic expect_state(input string tag, input int stb_exp, input logic [3:0] d_exp, input logic vt_exp);
    check({tag, "_stb_count"}, 32'(stb_cnt), 32'(stb_exp));
    check({tag, "_data_out"}, 32'(DATA_OUT), 32'(d_exp));
    check({tag, "_vt"}, 32'(VT), 32'(vt_exp));
  endtask

  initial begin
    int elapsed;
    logic [7:0] dbad;
    DIN = 1'b0;
    ADDR_CFG = 16'h5555;
    RST_N = 1'b0;
    repeat (5) @(negedge INPUT_CLK);
    check("reset_data_out", 32'(DATA_OUT), 32'h0);
    check("reset_vt", 32'(VT), 32'h0);
    check("reset_stb", 32'(WORD_STB), 32'h0);
    RST_N = 1'b1;
    line(1'b0, 31);

    // Two identical words confirm; a third pulses again
    good(4'hA);                     expect_state("w1", 0, 4'h0, 1'b0);
    sb_q.push_back(4'hA); good(4'hA); expect_state("w2", 1, 4'hA, 1'b1);
    sb_q.push_back(4'hA); good(4'hA); expect_state("w3", 2, 4'hA, 1'b1);

    // Silence: VT falls 2048 clocks after the last confirm, data latched
    elapsed = -1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge INPUT_CLK); #1;
      if (VT === 1'b0) begin elapsed = cyc - last_stb_cyc; break; end
    end
    check("vt_hold_cycles", 32'(elapsed), 32'd2048);
    check("latched_data", 32'(DATA_OUT), 32'hA);
    @(negedge INPUT_CLK);

    // Differing data replaces pending without output change
    good(4'h3);                     expect_state("d3", 2, 4'hA, 1'b0);
    good(4'h5);                     expect_state("d5a", 2, 4'hA, 1'b0);
    sb_q.push_back(4'h5); good(4'h5); expect_state("d5b", 3, 4'h5, 1'b1);

    // Address trit A3 = 1 against configured F clears pending
    send_word(16'h55D5, dc(4'h5));  expect_state("badaddr", 3, 4'h5, 1'b1);
    good(4'h5);                     expect_state("after_bad1", 3, 4'h5, 1'b1);
    sb_q.push_back(4'h5); good(4'h5); expect_state("after_bad2", 4, 4'h5, 1'b1);

    // Abort cases: each clears pending, then sync + two good words confirm
    for (int f = 0; f < 4; f++) begin
      case (f)
        0: begin dbad = dc(4'h5); dbad[5:4] = 2'b01; send_word(16'h5555, dbad); end
        1: send_word(16'h5556, dc(4'h5));
        2: begin
          for (int i = 0; i < 3; i++) send_trit(2'b01);
          line(1'b1, 6); line(1'b0, 31);
        end
        default: begin
          for (int i = 0; i < 3; i++) send_trit(2'b01);
          line(1'b1, 1); line(1'b0, 6); line(1'b1, 1); line(1'b0, 31);
        end
      endcase
      expect_state($sformatf("fault%0d", f), 4 + f, 4'h5, 1'b1);
      good(4'h5);
      expect_state($sformatf("fault%0d_g1", f), 4 + f, 4'h5, 1'b1);
      sb_q.push_back(4'h5); good(4'h5);
      expect_state($sformatf("fault%0d_g2", f), 5 + f, 4'h5, 1'b1);
    end

    // Reset in the middle of the second word
    good(4'h9);                     expect_state("rw1", 8, 4'h5, 1'b1);
    for (int i = 0; i < 5; i++) send_trit(2'b01);
    RST_N = 1'b0;
    #1;
    check("midreset_data_out", 32'(DATA_OUT), 32'h0);
    check("midreset_vt", 32'(VT), 32'h0);
    check("midreset_stb", 32'(WORD_STB), 32'h0);
    repeat (3) @(negedge INPUT_CLK);
    RST_N = 1'b1;
    for (int i = 5; i < 8; i++) send_trit(2'b01);
    for (int j = 0; j < 4; j++) send_trit(dc(4'h9)[2*j +: 2]);
    line(1'b0, 31);                 expect_state("rw2", 8, 4'h0, 1'b0);
    good(4'h9);                     expect_state("rw3", 8, 4'h0, 1'b0);
    sb_q.push_back(4'h9); good(4'h9); expect_state("rw4", 9, 4'h9, 1'b1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
